// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer types and geometry; FB_SWAP_CLEAR_EN adds the SWAP_CLEAR state
package fb_pkg;

    localparam int WIDTH     = 64;
    localparam int HALF_ROWS = 32;
    localparam int ADDR_W    = 11;

    localparam int RED_LSB   = 4;
    localparam int GREEN_LSB = 2;
    localparam int BLUE_LSB  = 0;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_FILL  = 2'd1,
        OP_SWAP  = 2'd2,
        OP_RSVD  = 2'd3
    } fb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_SWAP = 2'd2
`ifdef FB_SWAP_CLEAR_EN
        ,
        ST_SWAP_CLEAR = 2'd3
`endif
    } fb_state_t;

    // y[4:0]*WIDTH + x with WIDTH=64 is just a concatenation
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [4:0] y, input logic [5:0] x);
        return {y, x};
    endfunction

    function automatic logic [7:0] color_mask(input logic [7:0] c);
        return c & 8'h3F;
    endfunction

endpackage

// File: rtl/fb_fill_counter.sv
// rtl/fb_fill_counter.sv - 11-bit address sweep shared by FILL and SWAP_CLEAR
module fb_fill_counter
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              run_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - write side of the double-buffered LED framebuffer; FB_SWAP_CLEAR_EN clears the new back buffer after a swap
module framebuffer_writer
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [5:0]        cmd_x,
    input  logic [5:0]        cmd_y,
    input  logic [7:0]        cmd_color,
    input  logic              display_done,
    output logic              ram0_we,
    output logic [ADDR_W:0]   ram0_addr,
    output logic [7:0]        ram0_data,
    output logic              ram1_we,
    output logic [ADDR_W:0]   ram1_addr,
    output logic [7:0]        ram1_data,
    output logic              front_buf,
    output logic              busy
);

    fb_state_t         state_q, state_d;
    logic              front_q, front_d;
    logic [7:0]        fill_color_q, fill_color_d;
    logic              ram0_we_q, ram0_we_d, ram1_we_q, ram1_we_d;
    logic [ADDR_W:0]   ram0_addr_q, ram0_addr_d, ram1_addr_q, ram1_addr_d;
    logic [7:0]        ram0_data_q, ram0_data_d, ram1_data_q, ram1_data_d;
    logic              cnt_start, cnt_run, cnt_last;
    logic [ADDR_W-1:0] cnt;
    logic              accept;

    fb_fill_counter u_cnt (
        .clk     (clk),
        .rst     (rst),
        .start_i (cnt_start),
        .run_i   (cnt_run),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        front_d      = front_q;
        fill_color_d = fill_color_q;
        cnt_start    = 1'b0;
        cnt_run      = 1'b0;
        ram0_we_d    = 1'b0;
        ram1_we_d    = 1'b0;
        ram0_addr_d  = ram0_addr_q;
        ram1_addr_d  = ram1_addr_q;
        ram0_data_d  = ram0_data_q;
        ram1_data_d  = ram1_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (fb_op_t'(cmd_op))
                        OP_WRITE: begin
                            if (cmd_y[5]) begin
                                ram1_we_d   = 1'b1;
                                ram1_addr_d = {~front_q, pix_addr(cmd_y[4:0], cmd_x)};
                                ram1_data_d = color_mask(cmd_color);
                            end else begin
                                ram0_we_d   = 1'b1;
                                ram0_addr_d = {~front_q, pix_addr(cmd_y[4:0], cmd_x)};
                                ram0_data_d = color_mask(cmd_color);
                            end
                        end
                        OP_FILL: begin
                            fill_color_d = color_mask(cmd_color);
                            cnt_start    = 1'b1;
                            state_d      = ST_FILL;
                        end
                        OP_SWAP: state_d = ST_WAIT_SWAP;
                        default: ;
                    endcase
                end
            end
            ST_FILL: begin
                ram0_we_d   = 1'b1;
                ram1_we_d   = 1'b1;
                ram0_addr_d = {~front_q, cnt};
                ram1_addr_d = {~front_q, cnt};
                ram0_data_d = fill_color_q;
                ram1_data_d = fill_color_q;
                cnt_run     = 1'b1;
                if (cnt_last) state_d = ST_IDLE;
            end
            ST_WAIT_SWAP: begin
                if (display_done) begin
                    front_d = ~front_q;
`ifdef FB_SWAP_CLEAR_EN
                    cnt_start = 1'b1;
                    state_d   = ST_SWAP_CLEAR;
`else
                    state_d   = ST_IDLE;
`endif
                end
            end
`ifdef FB_SWAP_CLEAR_EN
            // front_q has already toggled, so ~front_q is the buffer just retired from display
            ST_SWAP_CLEAR: begin
                ram0_we_d   = 1'b1;
                ram1_we_d   = 1'b1;
                ram0_addr_d = {~front_q, cnt};
                ram1_addr_d = {~front_q, cnt};
                ram0_data_d = 8'h00;
                ram1_data_d = 8'h00;
                cnt_run     = 1'b1;
                if (cnt_last) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            front_q      <= 1'b0;
            fill_color_q <= '0;
            ram0_we_q    <= 1'b0;
            ram1_we_q    <= 1'b0;
            ram0_addr_q  <= '0;
            ram1_addr_q  <= '0;
            ram0_data_q  <= '0;
            ram1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            front_q      <= front_d;
            fill_color_q <= fill_color_d;
            ram0_we_q    <= ram0_we_d;
            ram1_we_q    <= ram1_we_d;
            ram0_addr_q  <= ram0_addr_d;
            ram1_addr_q  <= ram1_addr_d;
            ram0_data_q  <= ram0_data_d;
            ram1_data_q  <= ram1_data_d;
        end
    end

    assign ram0_we   = ram0_we_q;
    assign ram0_addr = ram0_addr_q;
    assign ram0_data = ram0_data_q;
    assign ram1_we   = ram1_we_q;
    assign ram1_addr = ram1_addr_q;
    assign ram1_data = ram1_data_q;
    assign front_buf = front_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - scoreboard bench for framebuffer_writer; honours FB_SWAP_CLEAR_EN
module tb_framebuffer_writer;

    typedef struct packed {
        logic        half;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_x = '0;
    logic [5:0]  cmd_y = '0;
    logic [7:0]  cmd_color = '0;
    logic        display_done = 1'b0;
    logic        ram0_we, ram1_we;
    logic [11:0] ram0_addr, ram1_addr;
    logic [7:0]  ram0_data, ram1_data;
    logic        front_buf, busy;

    int   checks = 0;
    int   errors = 0;
    wr_t  sb_q[$];
    logic sb_on = 1'b1;
    logic front_m = 1'b0;
    int   run_len = 0;
    int   max_run = 0;
    int   both_cnt = 0;

    framebuffer_writer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_color    (cmd_color),
        .display_done (display_done),
        .ram0_we      (ram0_we),
        .ram0_addr    (ram0_addr),
        .ram0_data    (ram0_data),
        .ram1_we      (ram1_we),
        .ram1_addr    (ram1_addr),
        .ram1_data    (ram1_data),
        .front_buf    (front_buf),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input logic half, input logic [11:0] addr, input logic [7:0] data);
        wr_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_write", 32'(addr), 32'hFFFF_FFFF);
        end else begin
            e = sb_q.pop_front();
            chk("wr_half", 32'(half), 32'(e.half));
            chk("wr_addr", 32'(addr), 32'(e.addr));
            chk("wr_data", 32'(data), 32'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (sb_on && rst) begin
            if (ram0_we) sb_pop(1'b0, ram0_addr, ram0_data);
            if (ram1_we) sb_pop(1'b1, ram1_addr, ram1_data);
            if (ram0_we || ram1_we) run_len++;
            else run_len = 0;
            if (run_len > max_run) max_run = run_len;
            if (ram0_we && ram1_we) both_cnt++;
        end
    end

    task automatic push_sweep(input logic msb, input logic [7:0] data);
        for (int i = 0; i < 2048; i++) begin
            sb_q.push_back({1'b0, msb, 11'(i), data});
            sb_q.push_back({1'b1, msb, 11'(i), data});
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                        input logic [7:0] c, input logic done);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c;
        display_done = done;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        if (op == 2'd0 && sb_on)
            sb_q.push_back({y[5], ~front_m, y[4:0], x, 2'b00, c[5:0]});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        display_done = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        // reset state, including ready during reset
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_we0", 32'(ram0_we), 32'd0);
        chk("rst_we1", 32'(ram1_we), 32'd0);
        chk("rst_addr0", 32'(ram0_addr), 32'd0);
        chk("rst_data1", 32'(ram1_data), 32'd0);
        chk("rst_front", 32'(front_buf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // single writes to each half
        send(2'd0, 6'd5, 6'd3, 8'hFF, 1'b0);
        @(negedge clk);
        chk("w1_we1_low", 32'(ram1_we), 32'd0);
        send(2'd0, 6'd63, 6'd63, 8'h15, 1'b0);
        @(negedge clk);
        chk("w2_addr_lit", 32'(ram1_addr), 32'hFFF);

        // back-to-back writes
        @(negedge clk);
        max_run = 0;
        send(2'd0, 6'd0,  6'd0,  8'h01, 1'b0);
        send(2'd0, 6'd1,  6'd33, 8'h82, 1'b0);
        send(2'd0, 6'd62, 6'd31, 8'hC3, 1'b0);
        send(2'd0, 6'd17, 6'd40, 8'h24, 1'b0);
        repeat (3) @(negedge clk);
        chk("b2b_run", 32'(max_run), 32'd4);
        chk("b2b_drained", 32'(sb_q.size()), 32'd0);

        // reserved op and display_done in IDLE are ignored
        send(2'd3, 6'd9, 6'd9, 8'h3F, 1'b1);
        repeat (2) @(negedge clk);
        chk("rsvd_busy", 32'(busy), 32'd0);
        chk("idle_done_front", 32'(front_buf), 32'(front_m));

        // fill
        both_cnt = 0;
        push_sweep(~front_m, 8'h2A);
        send(2'd1, 6'd0, 6'd0, 8'hEA, 1'b0);
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("fill_ready_low", 32'(n), 32'd2048);
        repeat (2) @(negedge clk);
        chk("fill_we_cycles", 32'(both_cnt), 32'd2048);
        chk("fill_drained", 32'(sb_q.size()), 32'd0);

        // swap: coincident done ignored, later done flips front
        send(2'd2, 6'd0, 6'd0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        chk("swap_front_hold", 32'(front_buf), 32'd0);
        chk("swap_busy", 32'(busy), 32'd1);
        chk("swap_not_ready", 32'(cmd_ready), 32'd0);
`ifdef FB_SWAP_CLEAR_EN
        both_cnt = 0;
        push_sweep(front_m, 8'h00);
`endif
        display_done = 1'b1;
        @(posedge clk);
        #1;
        display_done = 1'b0;
        front_m = ~front_m;
        @(negedge clk);
        chk("swap_front_flip", 32'(front_buf), 32'(front_m));
`ifdef FB_SWAP_CLEAR_EN
        chk("clear_busy", 32'(busy), 32'd1);
        wait_idle("clear_idle");
        repeat (2) @(negedge clk);
        chk("clear_we_cycles", 32'(both_cnt), 32'd2048);
`else
        chk("swap_idle", 32'(busy), 32'd0);
        chk("swap_ready", 32'(cmd_ready), 32'd1);
`endif
        send(2'd0, 6'd1, 6'd2, 8'h33, 1'b0);
        @(negedge clk);
        chk("post_swap_msb", 32'(ram0_addr[11]), 32'd0);

        // reset in the middle of a fill
        sb_on = 1'b0;
        send(2'd1, 6'd0, 6'd0, 8'h11, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_we0", 32'(ram0_we), 32'd0);
        chk("abort_we1", 32'(ram1_we), 32'd0);
        chk("abort_front", 32'(front_buf), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        front_m = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        sb_on = 1'b1;
        send(2'd0, 6'd7, 6'd40, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
